conv33_input_ctrl: RTL
======================

// Module: conv33_input_ctrl
// PURPOSE
//  Input-side controller of the 3x3 convolution datapath; pairs with the output controller.
//  Accepts a raster-order pixel stream (valid/ready) from upstream and drives line-buffer writes
//  (column address, rotating row slot). Tells the compute engine when a full 3x3 window is resident.
//  One frame of IMG_W x IMG_H pixels per start pulse.
// PARAMETERS
//  DATA_W   8   pixel width in bits
//  IMG_W    28  pixels per row (>=3)
//  IMG_H    28  rows per frame (>=3)
//  COL_W    5   column counter width, must satisfy 2**COL_W >= IMG_W
//  ROW_W    5   row counter width, must satisfy 2**ROW_W >= IMG_H
// PORTS
//  clk          in   1       clock
//  rst          in   1       async reset, active-high
//  start        in   1       one-cycle pulse; begins a frame when idle
//  calc_ready   in   1       compute engine can accept a window this cycle
//  in_valid     in   1       upstream pixel valid
//  in_data      in   DATA_W  upstream pixel
//  in_ready     out  1       pixel accepted when in_valid && in_ready
//  buf_wr_en    out  1       line-buffer write strobe
//  buf_wr_data  out  DATA_W  pixel to write
//  buf_wr_col   out  COL_W   column address of write
//  buf_wr_slot  out  2       row slot 0..2 of write (rotating)
//  win_valid    out  1       3x3 window ending at last written pixel is ready
//  win_row      out  ROW_W   output row of window (top-left row)
//  win_col      out  COL_W   output column of window (top-left col)
//  busy         out  1       high in RUN
//  frame_done   out  1       one-cycle pulse after last pixel of frame written
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, col/row/slot counters 0.
//  - FSM IDLE -> RUN on start. RUN -> DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
//    DONE -> IDLE after one cycle. start in RUN or DONE is ignored.
//  - in_ready = (state==RUN) && calc_ready; combinational; 0 in IDLE and DONE.
//  - Accept cycle: col++; at col==IMG_W-1, col<=0, row++, slot<=(slot==2)?0:slot+1.
//  - Registered write, 1-cycle latency: cycle after accept, buf_wr_en=1 with the accepted
//    data, col and slot. Otherwise buf_wr_en=0; other buf_* hold.
//  - win_valid asserted in the same cycle as buf_wr_en when accepted row>=2 and col>=2.
//    Then win_row=row-2, win_col=col-2. win_valid pulses once per window:
//    (IMG_H-2)*(IMG_W-2) per frame, never for rows 0-1 or cols 0-1.
//  - frame_done = 1 in the DONE cycle, coincident with the final buf_wr_en/win_valid.
//    busy = 1 in RUN only.
//  - calc_ready low stalls acceptance; counters hold; no write or window that cycle.
//  - Upstream may drop in_valid at any time; counters advance only on acceptance.
//  - Reset mid-frame: immediate return to IDLE, counters 0, pending write/window discarded.
//  - Counter arithmetic unsigned; row/col never exceed IMG_H-1 / IMG_W-1.
//  - slot wraps 2->0 and restarts at 0 each frame.
// STRUCTURE
//  - Shared include conv33_defs.vh: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//    default IMG_W/IMG_H/DATA_W, slot count constant 3.
//  - One sub-module: conv33_raster_cnt, the col/row/slot counter with inc and clear inputs,
//    and last_col/last_pix flags.
//  - Top holds FSM, ready logic and output register stage.
// TESTING
//  1. Reset then idle, in_valid=1 with no start -> in_ready=0; no buf_wr_en or win_valid ever.
//  2. IMG_W=IMG_H=4, start, 16 back-to-back pixels 0..15 -> 16 writes.
//     win_valid at pixels 10,11,14,15 with (row,col)=(0,0),(0,1),(1,0),(1,1);
//     frame_done with the 16th write.
//  3. Slot rotation, 28x28 frame -> buf_wr_slot sequence 0,1,2,0,... per row.
//     Last row (27) writes slot 0.
//  4. calc_ready low for 5 cycles mid-row -> in_ready=0; counters frozen;
//     resumes with no lost or duplicated pixel.
//  5. Assert rst at pixel 100 of a 28x28 frame -> all outputs 0 next edge.
//     A new start then writes col 0 / slot 0 first.
//  6. start pulsed during RUN -> ignored. A second start after frame_done runs a full
//     second frame with identical win_valid count (676).

Source files
------------

// File: rtl/conv33_input_ctrl_pkg.sv
`timescale 1ns/1ps
// conv33_input_ctrl_pkg
//  Shared definitions for the input side of the 3x3 convolution datapath:
//  controller state encoding, default frame geometry, the number of rotating
//  line-buffer row slots and a helper that advances a slot index.
package conv33_input_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_IMG_W  = 28;
   localparam int DEF_IMG_H  = 28;
   localparam int NUM_SLOTS  = 3;

   // Three line-buffer rows are reused round-robin, so the slot wraps 2 -> 0.
   function automatic logic [1:0] next_slot(input logic [1:0] slot);
      return (slot == 2'(NUM_SLOTS - 1)) ? 2'd0 : slot + 2'd1;
   endfunction

endpackage

// File: rtl/conv33_raster_cnt.sv
`timescale 1ns/1ps
// conv33_raster_cnt
//  Raster position counter for the input controller. Tracks column, row and
//  rotating line-buffer slot of the next pixel to be accepted.
// Ports
//  clk, rst        clock, async active-high reset
//  inc             advance one pixel in raster order
//  clear           return to the top-left pixel, slot 0 (wins over inc)
//  col, row, slot  current position / row slot
//  last_col        current pixel is the last one of its row
//  last_pix        current pixel is the last one of the frame
module conv33_raster_cnt
   import conv33_input_ctrl_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int COL_W = 5,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic [1:0]       slot,
   output logic             last_col,
   output logic             last_pix
);

   assign last_col = (col == COL_W'(IMG_W - 1));
   assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));

   // Position update. After the final pixel every counter folds back to zero
   // so the row never exceeds IMG_H-1 and the next frame starts in slot 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         slot <= 2'd0;
      end else if (clear) begin
         col  <= '0;
         row  <= '0;
         slot <= 2'd0;
      end else if (inc) begin
         if (last_col) begin
            col <= '0;
            if (last_pix) begin
               row  <= '0;
               slot <= 2'd0;
            end else begin
               row  <= row + ROW_W'(1);
               slot <= next_slot(slot);
            end
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/conv33_input_ctrl.sv
`timescale 1ns/1ps
// conv33_input_ctrl
//  Input-side controller of the 3x3 convolution datapath. Accepts a raster
//  pixel stream, writes each pixel into a three-row rotating line buffer one
//  cycle after acceptance and flags when a full 3x3 window has become
//  resident. One IMG_W x IMG_H frame per start pulse.
// Ports
//  clk, rst                    clock, async active-high reset
//  start                       begins a frame when idle
//  calc_ready                  compute engine can take a window this cycle
//  in_valid, in_data, in_ready upstream pixel handshake
//  buf_wr_en/data/col/slot     registered line-buffer write
//  win_valid, win_row, win_col window ready, top-left coordinate of window
//  busy                        frame in progress
//  frame_done                  pulse with the final write of the frame
module conv33_input_ctrl
   import conv33_input_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int COL_W  = 5,
   parameter int ROW_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              calc_ready,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              buf_wr_en,
   output logic [DATA_W-1:0] buf_wr_data,
   output logic [COL_W-1:0]  buf_wr_col,
   output logic [1:0]        buf_wr_slot,
   output logic              win_valid,
   output logic [ROW_W-1:0]  win_row,
   output logic [COL_W-1:0]  win_col,
   output logic              busy,
   output logic              frame_done
);

   state_t           state;
   state_t           state_n;
   logic             accept;
   logic             cnt_clear;
   logic             frame_end;
   logic             win_hit;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [1:0]       slot;
   logic             last_col;
   logic             last_pix;

   assign in_ready   = (state == ST_RUN) && calc_ready;
   assign accept     = in_valid && in_ready;
   assign cnt_clear  = (state == ST_IDLE) && start;
   assign frame_end  = accept && last_col && last_pix;
   assign win_hit    = (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign busy       = (state == ST_RUN);
   assign frame_done = (state == ST_DONE);

   conv33_raster_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (accept),
      .clear    (cnt_clear),
      .col      (col),
      .row      (row),
      .slot     (slot),
      .last_col (last_col),
      .last_pix (last_pix)
   );

   // State register for the frame controller.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic. start is only honoured in IDLE; DONE lasts exactly one
   // cycle so frame_done lines up with the write of the final pixel.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (start) state_n = ST_RUN;
         ST_RUN:  if (frame_end) state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Output stage: the accepted pixel and its position are registered so the
   // write and the window flag appear together one cycle after acceptance.
   // Address/data hold between writes; window coordinates only update when a
   // window actually completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_wr_en   <= 1'b0;
         buf_wr_data <= '0;
         buf_wr_col  <= '0;
         buf_wr_slot <= 2'd0;
         win_valid   <= 1'b0;
         win_row     <= '0;
         win_col     <= '0;
      end else begin
         buf_wr_en <= accept;
         win_valid <= accept && win_hit;
         if (accept) begin
            buf_wr_data <= in_data;
            buf_wr_col  <= col;
            buf_wr_slot <= slot;
         end
         if (accept && win_hit) begin
            win_row <= row - ROW_W'(2);
            win_col <= col - COL_W'(2);
         end
      end
   end

endmodule
